// File: rtl/port_rx_pkg.sv
// Shared types and helpers for the switch-port receive unpacker.
package port_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_REQ,
    HDR_CAP,
    PAY_REQ,
    PAY_CAP,
    PAR_REQ,
    PAR_CAP,
    DONE
  } rx_state_e;

  localparam int HDR_BYTES = 3;

  function automatic logic [7:0] calc_parity(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/rx_out_reg.sv
// One-entry payload holding register with valid/ready and a last-byte marker.
module rx_out_reg (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       last_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       last_o
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= 8'd0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/port_rx_unpacker.sv
// Frames DA/SA/LEN/payload/parity bytes popped from one switch port and streams the payload.
// Defining PORT_RX_STATS_EN adds saturating good/bad packet counters (stat_good, stat_bad).
module port_rx_unpacker
  import port_rx_pkg::*;
#(
  parameter int unsigned MAX_LEN = 64,
  parameter logic [7:0]  PORT_ID = 8'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  port_data,
  input  logic        port_ready,
  output logic        port_read,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [7:0]  pkt_da,
  output logic [7:0]  pkt_sa,
  output logic [7:0]  pkt_len,
  output logic        pkt_done,
  output logic        parity_err,
  output logic        len_err,
  output logic        da_err
`ifdef PORT_RX_STATS_EN
  ,
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad
`endif
);

  rx_state_e  state_q, state_d;
  logic [1:0] hdr_cnt_q, hdr_cnt_d;
  logic [7:0] pay_cnt_q, pay_cnt_d;
  logic [7:0] par_q, par_d;
  logic [7:0] da_q, da_d, sa_q, sa_d, len_q, len_d;
  logic       perr_q, perr_d, lerr_q, lerr_d, derr_q, derr_d;
  logic       load, load_last;

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    pay_cnt_d = pay_cnt_q;
    par_d     = par_q;
    da_d      = da_q;
    sa_d      = sa_q;
    len_d     = len_q;
    perr_d    = perr_q;
    lerr_d    = lerr_q;
    derr_d    = derr_q;
    port_read = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    case (state_q)
      IDLE: begin
        hdr_cnt_d = 2'd0;
        if (port_ready) state_d = HDR_REQ;
      end
      HDR_REQ: begin
        if (port_ready) begin
          port_read = 1'b1;
          state_d   = HDR_CAP;
        end
      end
      HDR_CAP: begin
        case (hdr_cnt_q)
          2'd0: begin
            da_d   = port_data;
            par_d  = port_data;
            derr_d = (port_data != PORT_ID);
          end
          2'd1: begin
            sa_d  = port_data;
            par_d = calc_parity(par_q, port_data);
          end
          default: begin
            len_d     = port_data;
            par_d     = calc_parity(par_q, port_data);
            lerr_d    = (32'(port_data) > MAX_LEN);
            pay_cnt_d = 8'd0;
          end
        endcase
        if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
          state_d = (port_data == 8'd0) ? PAR_REQ : PAY_REQ;
        end else begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          state_d   = HDR_REQ;
        end
      end
      PAY_REQ: begin
        // Only pop once the holding register is guaranteed free at capture time.
        if (port_ready && (!out_valid || out_ready)) begin
          port_read = 1'b1;
          state_d   = PAY_CAP;
        end
      end
      PAY_CAP: begin
        load      = 1'b1;
        load_last = (pay_cnt_q == len_q - 8'd1);
        par_d     = calc_parity(par_q, port_data);
        pay_cnt_d = pay_cnt_q + 8'd1;
        state_d   = load_last ? PAR_REQ : PAY_REQ;
      end
      PAR_REQ: begin
        if (port_ready) begin
          port_read = 1'b1;
          state_d   = PAR_CAP;
        end
      end
      PAR_CAP: begin
        perr_d  = (port_data != par_q);
        state_d = DONE;
      end
      DONE: begin
        if (!out_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hdr_cnt_q <= 2'd0;
      pay_cnt_q <= 8'd0;
      par_q     <= 8'd0;
      da_q      <= 8'd0;
      sa_q      <= 8'd0;
      len_q     <= 8'd0;
      perr_q    <= 1'b0;
      lerr_q    <= 1'b0;
      derr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      pay_cnt_q <= pay_cnt_d;
      par_q     <= par_d;
      da_q      <= da_d;
      sa_q      <= sa_d;
      len_q     <= len_d;
      perr_q    <= perr_d;
      lerr_q    <= lerr_d;
      derr_q    <= derr_d;
    end
  end

  rx_out_reg u_out_reg (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (load),
    .data_i  (port_data),
    .last_i  (load_last),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .last_o  (out_last)
  );

  // Done fires only once the last payload byte has left the holding register.
  assign pkt_done   = (state_q == DONE) && !out_valid;
  assign parity_err = pkt_done && perr_q;
  assign len_err    = pkt_done && lerr_q;
  assign da_err     = pkt_done && derr_q;
  assign pkt_da     = da_q;
  assign pkt_sa     = sa_q;
  assign pkt_len    = len_q;

`ifdef PORT_RX_STATS_EN
  logic [15:0] good_q, bad_q;
  logic        any_err;

  assign any_err = perr_q || lerr_q || derr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      good_q <= 16'd0;
      bad_q  <= 16'd0;
    end else if (pkt_done) begin
      if (any_err) begin
        if (bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
      end else begin
        if (good_q != 16'hFFFF) good_q <= good_q + 16'd1;
      end
    end
  end

  assign stat_good = good_q;
  assign stat_bad  = bad_q;
`endif

endmodule

// File: tb/tb_port_rx_unpacker.sv
// Scoreboard bench for port_rx_unpacker: FIFO source model, payload and packet queues.
module tb_port_rx_unpacker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] port_data = 8'd0;
  logic       port_ready = 1'b0;
  logic       port_read;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready = 1'b1;
  logic [7:0] pkt_da, pkt_sa, pkt_len;
  logic       pkt_done, parity_err, len_err, da_err;
`ifdef PORT_RX_STATS_EN
  logic [15:0] stat_good, stat_bad;
`endif

  port_rx_unpacker #(.MAX_LEN(64), .PORT_ID(8'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .port_data  (port_data),
    .port_ready (port_ready),
    .port_read  (port_read),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .pkt_da     (pkt_da),
    .pkt_sa     (pkt_sa),
    .pkt_len    (pkt_len),
    .pkt_done   (pkt_done),
    .parity_err (parity_err),
    .len_err    (len_err),
    .da_err     (da_err)
`ifdef PORT_RX_STATS_EN
    ,
    .stat_good  (stat_good),
    .stat_bad   (stat_bad)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } pay_t;

  typedef struct {
    logic [7:0] da, sa, len;
    logic       perr, lerr, derr;
  } pkt_t;

  pay_t       exp_pay[$];
  pkt_t       exp_pkt[$];
  logic [7:0] fifo[$];
  logic       src_en = 1'b1;
  int         total = 0;
  int         bad = 0;
  int         done_cnt = 0;
  int         read_viol = 0;
  int         good_exp = 0;
  int         bad_exp = 0;
  pay_t       mon_pay;
  pkt_t       mon_pkt;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Switch port FIFO model: byte presented before the edge following the read.
  always @(negedge clk) begin
    if (port_read) begin
      if (!port_ready) read_viol++;
      if (fifo.size() > 0) port_data = fifo.pop_front();
    end
  end

  always @(posedge clk) begin
    #1;
    port_ready = src_en && (fifo.size() > 0);
  end

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        if (exp_pay.size() == 0) begin
          total++;
          bad++;
          $display("FAIL payload: unexpected byte %h", out_data);
        end else begin
          mon_pay = exp_pay.pop_front();
          chk8("out_data", out_data, mon_pay.data);
          chk1("out_last", out_last, mon_pay.last);
        end
      end
      if (pkt_done) begin
        done_cnt++;
        if (exp_pkt.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pkt_done: unexpected pulse");
        end else begin
          mon_pkt = exp_pkt.pop_front();
          chk8("pkt_da", pkt_da, mon_pkt.da);
          chk8("pkt_sa", pkt_sa, mon_pkt.sa);
          chk8("pkt_len", pkt_len, mon_pkt.len);
          chk1("parity_err", parity_err, mon_pkt.perr);
          chk1("len_err", len_err, mon_pkt.lerr);
          chk1("da_err", da_err, mon_pkt.derr);
          chk_int("payload_drained_at_done", exp_pay.size(), 0);
          if (mon_pkt.perr || mon_pkt.lerr || mon_pkt.derr) bad_exp++;
          else good_exp++;
        end
      end
    end
  end

  task automatic send_pkt(input logic [7:0] da, input logic [7:0] sa,
                          input logic [7:0] len, input bit bad_par);
    logic [7:0] par;
    pay_t       e;
    pkt_t       p;
    par = da ^ sa ^ len;
    fifo.push_back(da);
    fifo.push_back(sa);
    fifo.push_back(len);
    for (int i = 0; i < int'(len); i++) begin
      e.data = 8'(i + 1);
      e.last = (i == int'(len) - 1);
      par    = par ^ e.data;
      exp_pay.push_back(e);
      fifo.push_back(e.data);
    end
    fifo.push_back(bad_par ? 8'hFF : par);
    p.da   = da;
    p.sa   = sa;
    p.len  = len;
    p.perr = bad_par && (par != 8'hFF);
    p.lerr = (len > 8'd64);
    p.derr = (da != 8'd0);
    exp_pkt.push_back(p);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (done_cnt < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL %s: timeout done_cnt=%0d want %0d", name, done_cnt, target);
    end
  endtask

  task automatic wait_pay_left(input int left, input int budget, input string name);
    int c;
    c = 0;
    while (exp_pay.size() > left && c < budget) begin
      @(posedge clk);
      c++;
    end
    total++;
    if (exp_pay.size() > left) begin
      bad++;
      $display("FAIL %s: timeout remaining=%0d", name, exp_pay.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n_done;
    int         c;
    int         stable_bad;
    logic [7:0] hold;

    n_done = 0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_port_read", port_read, 1'b0);
    chk1("rst_pkt_done", pkt_done, 1'b0);
    chk8("rst_pkt_da", pkt_da, 8'h00);
    chk8("rst_pkt_len", pkt_len, 8'h00);
    chk8("rst_out_data", out_data, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    send_pkt(8'h00, 8'h11, 8'd4, 1'b0);
    n_done++; wait_done(n_done, 300, "good_pkt");
    send_pkt(8'h00, 8'h11, 8'd4, 1'b1);
    n_done++; wait_done(n_done, 300, "bad_parity");
    send_pkt(8'h00, 8'h05, 8'd0, 1'b0);
    n_done++; wait_done(n_done, 300, "len_zero");
    send_pkt(8'h00, 8'h22, 8'd70, 1'b0);
    n_done++; wait_done(n_done, 1000, "len_70");
    send_pkt(8'h02, 8'h44, 8'd64, 1'b0);
    n_done++; wait_done(n_done, 1000, "len_64_da_err");
    send_pkt(8'h00, 8'h55, 8'd65, 1'b0);
    n_done++; wait_done(n_done, 1000, "len_65");

    // Sink back-pressure on the first payload byte
    send_pkt(8'h00, 8'h33, 8'd4, 1'b0);
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!out_valid && c < 300);
    chk1("stall_first_valid", out_valid, 1'b1);
    out_ready = 1'b0;
    hold = out_data;
    stable_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_data !== hold || !out_valid || port_read) stable_bad++;
    end
    chk_int("stall_hold_stable", stable_bad, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    n_done++; wait_done(n_done, 300, "stall_release");

    // Source starvation mid-payload
    send_pkt(8'h00, 8'h66, 8'd6, 1'b0);
    wait_pay_left(4, 300, "starve_wait");
    src_en = 1'b0;
    repeat (5) @(posedge clk);
    src_en = 1'b1;
    n_done++; wait_done(n_done, 300, "starve_complete");

    // Reset during payload byte 2
    send_pkt(8'h00, 8'h77, 8'd8, 1'b0);
    wait_pay_left(7, 300, "reset_wait");
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_out_last", out_last, 1'b0);
    chk1("midrst_port_read", port_read, 1'b0);
    chk1("midrst_pkt_done", pkt_done, 1'b0);
    chk8("midrst_pkt_da", pkt_da, 8'h00);
    chk8("midrst_pkt_sa", pkt_sa, 8'h00);
    fifo.delete();
    exp_pay.delete();
    exp_pkt.delete();
    good_exp = 0;
    bad_exp = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    send_pkt(8'h00, 8'h88, 8'd5, 1'b0);
    n_done++; wait_done(n_done, 300, "post_reset_pkt");
    send_pkt(8'h00, 8'h99, 8'd2, 1'b0);
    n_done++; wait_done(n_done, 300, "post_reset_good2");
    send_pkt(8'h00, 8'hAA, 8'd3, 1'b0);
    n_done++; wait_done(n_done, 300, "post_reset_good3");
    send_pkt(8'h00, 8'hBB, 8'd3, 1'b1);
    n_done++; wait_done(n_done, 300, "post_reset_bad");

    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef PORT_RX_STATS_EN
    chk_int("stat_good", int'(stat_good), good_exp);
    chk_int("stat_bad", int'(stat_bad), bad_exp);
`endif
    chk_int("good_after_reset", good_exp, 3);
    chk_int("bad_after_reset", bad_exp, 1);
    chk_int("read_while_not_ready", read_viol, 0);
    chk_int("leftover_payload", exp_pay.size(), 0);
    chk_int("leftover_packets", exp_pkt.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
